// File: rtl/pc_defs.sv
// Shared definitions for the program-counter stage: FSM encoding, default widths
// and the fixed PC increments.
package pc_defs;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int PC_W_DEF  = 8;
  localparam int OFF_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  localparam int SEQ_INC  = 1;
  localparam int SKIP_INC = 2;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC datapath. The sum is one bit wider than the PC so the
// top bit flags overflow on add and borrow on subtract.
module pc_next_calc
  import pc_defs::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OFF_W = OFF_W_DEF
) (
  input  logic [PC_W-1:0]  pc,
  input  logic             branch_en,
  input  logic             branch_sub,
  input  logic [OFF_W-1:0] branch_off,
  input  logic             skip_en,
  output logic [PC_W-1:0]  next_pc,
  output logic             next_wrap
);

  logic [PC_W:0] pc_ext;
  logic [PC_W:0] off_ext;
  logic [PC_W:0] sum;

  assign pc_ext  = {1'b0, pc};
  assign off_ext = {{(PC_W + 1 - OFF_W){1'b0}}, branch_off};

  // Branch beats skip beats sequential; the caller gates the enables by state.
  always_comb begin
    sum = pc_ext + (PC_W + 1)'(SEQ_INC);
    if (branch_en) begin
      if (branch_sub) sum = pc_ext - off_ext;
      else            sum = pc_ext + off_ext;
    end else if (skip_en) begin
      sum = pc_ext + (PC_W + 1)'(SKIP_INC);
    end
  end

  assign next_pc   = sum[PC_W-1:0];
  assign next_wrap = sum[PC_W];

endmodule

// File: rtl/unidade_pc.sv
// Program-counter stage: PC register, BOOT/RUN/HALT fetch control, registered
// wrap flag and a saturating retired-instruction counter.
module unidade_pc
  import pc_defs::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              OFF_W    = OFF_W_DEF,
  parameter int              CNT_W    = CNT_W_DEF,
  parameter logic [PC_W-1:0] PC_RESET = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             branch_en,
  input  logic             branch_sub,
  input  logic [OFF_W-1:0] branch_off,
  input  logic             skip_en,
  input  logic             halt_req,
  input  logic             resume,
  output logic [PC_W-1:0]  pc,
  output logic             instr_valid,
  output logic             halted,
  output logic             pc_wrap,
  output logic [CNT_W-1:0] retired
);

  pc_state_t       state;
  logic            calc_branch;
  logic            calc_skip;
  logic [PC_W-1:0] next_pc;
  logic            next_wrap;

  // Outside RUN the calculator falls back to pc + 1, which is exactly the resume step.
  assign calc_branch = branch_en && (state == RUN);
  assign calc_skip   = skip_en   && (state == RUN);

  pc_next_calc #(
    .PC_W (PC_W),
    .OFF_W(OFF_W)
  ) u_next (
    .pc        (pc),
    .branch_en (calc_branch),
    .branch_sub(branch_sub),
    .branch_off(branch_off),
    .skip_en   (calc_skip),
    .next_pc   (next_pc),
    .next_wrap (next_wrap)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= BOOT;
      pc      <= PC_RESET;
      pc_wrap <= 1'b0;
      retired <= '0;
    end else begin
      pc_wrap <= 1'b0;
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (retired != '1) retired <= retired + CNT_W'(1);
          if (halt_req) begin
            state <= HALT;
          end else begin
            pc      <= next_pc;
            pc_wrap <= next_wrap;
          end
        end
        HALT: begin
          if (resume) begin
            state   <= RUN;
            pc      <= next_pc;
            pc_wrap <= next_wrap;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign instr_valid = (state == RUN);
  assign halted      = (state == HALT);

endmodule
